// File: rtl/nd_loop_sequencer.sv
// nd_loop_sequencer: N-D loop nest walker. Each accepted config yields one index tuple per handshake.
// Latency: first tuple is visible the cycle after the config is accepted. Tuples hold while unacked.
// Optional abort input via `define ND_SEQ_ABORT_EN.
module nd_loop_sequencer #(
    parameter  int BW  = 8,
    parameter  int DIM = 2,
    localparam int RW  = $clog2(DIM+1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cfg_rdy,
    output logic                     o_cfg_ack,
    input  logic [DIM-1:0][BW-1:0]   i_beg,
    input  logic [DIM-1:0][BW-1:0]   i_stride,
    input  logic [DIM-1:0][BW-1:0]   i_end,
    output logic                     o_dst_rdy,
    input  logic                     i_dst_ack,
    output logic [DIM-1:0][BW-1:0]   o_id,
    output logic [DIM-1:0][BW-1:0]   o_id_noofs,
    output logic                     o_last,
    output logic [RW-1:0]            o_retire
`ifdef ND_SEQ_ABORT_EN
    ,
    input  logic                     i_abort
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   r_state, w_nxt_state;
    logic [DIM-1:0][BW-1:0]   r_beg, r_stride, r_end, r_id, r_noofs;
    logic [DIM-1:0][BW-1:0]   w_sum, w_nxt_id, w_nxt_noofs;
    logic [DIM-1:0]           w_wrap;
    logic [RW-1:0]            w_k;
    logic                     w_run, w_full, w_empty, w_abort;
    logic                     w_xfer, w_cfg_xfer, w_step;

`ifdef ND_SEQ_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Carry chain: count consecutive innermost dims whose next value hits end.
    always_comb begin
        w_k   = '0;
        w_run = 1'b1;
        for (int d = DIM-1; d >= 0; d--) begin
            w_sum[d]  = r_id[d] + r_stride[d];
            w_wrap[d] = (w_sum[d] == r_end[d]);
            if (w_run && w_wrap[d]) begin
                w_k = w_k + RW'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_full = (w_k == RW'(DIM));

    always_comb begin
        for (int d = 0; d < DIM; d++) begin
            w_nxt_id[d]    = r_id[d];
            w_nxt_noofs[d] = r_noofs[d];
            if (d > DIM - 1 - int'(w_k)) begin
                w_nxt_id[d]    = r_beg[d];
                w_nxt_noofs[d] = '0;
            end else if (d == DIM - 1 - int'(w_k)) begin
                w_nxt_id[d]    = w_sum[d];
                w_nxt_noofs[d] = r_noofs[d] + r_stride[d];
            end
        end
    end

    always_comb begin
        w_empty = 1'b0;
        for (int d = 0; d < DIM; d++) begin
            if (i_beg[d] == i_end[d]) begin
                w_empty = 1'b1;
            end
        end
    end

    assign o_dst_rdy  = (r_state == RUN);
    assign o_last     = o_dst_rdy && w_full;
    assign o_retire   = o_dst_rdy ? w_k : '0;
    assign o_id       = r_id;
    assign o_id_noofs = r_noofs;

    assign w_xfer     = o_dst_rdy && i_dst_ack;
    assign w_cfg_xfer = i_cfg_rdy && o_cfg_ack;
    assign w_step     = w_xfer && !w_full && !w_abort;

    // Accepting on the final transfer lets the next nest start with no bubble.
    always_comb begin
        w_nxt_state = r_state;
        o_cfg_ack   = ((r_state == IDLE) || (w_xfer && w_full)) && !w_abort;
        if ((r_state == RUN) && w_abort) begin
            w_nxt_state = IDLE;
        end else if (i_cfg_rdy && o_cfg_ack) begin
            w_nxt_state = w_empty ? IDLE : RUN;
        end else if (w_xfer && w_full) begin
            w_nxt_state = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_beg    <= '0;
            r_stride <= '0;
            r_end    <= '0;
            r_id     <= '0;
            r_noofs  <= '0;
        end else if (w_cfg_xfer && !w_empty) begin
            r_beg    <= i_beg;
            r_stride <= i_stride;
            r_end    <= i_end;
            r_id     <= i_beg;
            r_noofs  <= '0;
        end else if (w_step) begin
            r_id     <= w_nxt_id;
            r_noofs  <= w_nxt_noofs;
        end
    end

endmodule
